// File: rtl/arb_requester.sv
// Client-side requester for the N-way round-robin arbiter: one IDLE/REQ/OWN FSM per client.
// Optional protocol checker on the grant vector is compiled in when ARB_REQ_CHECK_EN is defined.
module arb_requester #(
    parameter int N       = 3,
    parameter int LEN_W   = 4,
    parameter int TIMEOUT = 15,
    localparam int OWN_W  = (N > 1) ? $clog2(N) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N-1:0]       start,
    input  logic [N*LEN_W-1:0] len,
    output logic [N-1:0]       r,
    input  logic [N-1:0]       g,
    output logic [N-1:0]       busy,
    output logic [N-1:0]       done,
    output logic [N-1:0]       err_timeout,
    output logic               beat_valid,
    output logic [OWN_W-1:0]   beat_owner,
    output logic [LEN_W-1:0]   beat_idx,
    output logic               err_proto
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_OWN  = 2'd2
    } state_t;

    // Last wait count before the abort fires; the grant check precedes it so a grant on that edge wins.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t           r_state [N];
    logic [LEN_W-1:0] r_len   [N];
    logic [LEN_W-1:0] r_beat  [N];
    logic [7:0]       r_wait  [N];
    logic [N-1:0]     r_req;
    logic [N-1:0]     r_busy;
    logic [N-1:0]     r_done;
    logic [N-1:0]     r_tmo;

    // NOTE: sequential state uses non-blocking assignments so every client FSM sees pre-edge values.
    // NOTE: the per-client arrays are tiny flop banks, not RAM, so they are reset like any other register.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                r_state[i] <= ST_IDLE;
                r_len[i]   <= '0;
                r_beat[i]  <= '0;
                r_wait[i]  <= '0;
            end
            r_req  <= '0;
            r_busy <= '0;
            r_done <= '0;
            r_tmo  <= '0;
        end else begin
            r_done <= '0;
            r_tmo  <= '0;
            for (int i = 0; i < N; i++) begin
                case (r_state[i])
                    ST_IDLE: begin
                        if (start[i]) begin
                            r_state[i] <= ST_REQ;
                            r_len[i]   <= len[i*LEN_W +: LEN_W];
                            r_beat[i]  <= '0;
                            r_wait[i]  <= '0;
                            r_req[i]   <= 1'b1;
                            r_busy[i]  <= 1'b1;
                        end
                    end
                    ST_REQ: begin
                        if (g[i]) begin
                            r_state[i] <= ST_OWN;
                        end else if (r_wait[i] == WAIT_LAST) begin
                            r_state[i] <= ST_IDLE;
                            r_req[i]   <= 1'b0;
                            r_busy[i]  <= 1'b0;
                            r_tmo[i]   <= 1'b1;
                        end else if (r_wait[i] != 8'hFF) begin
                            r_wait[i] <= r_wait[i] + 8'd1;
                        end
                    end
                    ST_OWN: begin
                        // A cycle without grant is a stall: the beat counter simply holds.
                        if (g[i]) begin
                            if (r_beat[i] == r_len[i]) begin
                                r_state[i] <= ST_IDLE;
                                r_req[i]   <= 1'b0;
                                r_busy[i]  <= 1'b0;
                                r_done[i]  <= 1'b1;
                            end else begin
                                r_beat[i] <= r_beat[i] + 1'b1;
                            end
                        end
                    end
                    default: begin
                        r_state[i] <= ST_IDLE;
                        r_req[i]   <= 1'b0;
                        r_busy[i]  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign r           = r_req;
    assign busy        = r_busy;
    assign done        = r_done;
    assign err_timeout = r_tmo;

    // Descending scan so the lowest-indexed beating client is the one reported.
    always_comb begin
        beat_valid = 1'b0;
        beat_owner = '0;
        beat_idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (r_state[i] == ST_OWN && g[i]) begin
                beat_valid = 1'b1;
                beat_owner = OWN_W'(i);
                beat_idx   = r_beat[i];
            end
        end
    end

`ifdef ARB_REQ_CHECK_EN
    logic r_err_proto;
    logic w_bad_grant;

    assign w_bad_grant = !$onehot0(g) || ((g & ~r_req) != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_proto <= 1'b0;
        end else if (w_bad_grant) begin
            r_err_proto <= 1'b1;
        end
    end

    assign err_proto = r_err_proto;
`else
    assign err_proto = 1'b0;
`endif

endmodule

// File: tb/tb_arb_requester.sv
// Directed bench for arb_requester: a vector table for burst/contention/stall traffic,
// plus hand-written sequences for timeout, reset mid-burst and the protocol checker.
module tb_arb_requester;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  start;
    logic [11:0] len;
    logic [2:0]  g;
    logic [2:0]  r;
    logic [2:0]  busy;
    logic [2:0]  done;
    logic [2:0]  err_timeout;
    logic        beat_valid;
    logic [1:0]  beat_owner;
    logic [3:0]  beat_idx;
    logic        err_proto;

`ifdef ARB_REQ_CHECK_EN
    localparam logic EXP_PROTO = 1'b1;
`else
    localparam logic EXP_PROTO = 1'b0;
`endif

    arb_requester #(.N(3), .LEN_W(4), .TIMEOUT(15)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .len         (len),
        .r           (r),
        .g           (g),
        .busy        (busy),
        .done        (done),
        .err_timeout (err_timeout),
        .beat_valid  (beat_valid),
        .beat_owner  (beat_owner),
        .beat_idx    (beat_idx),
        .err_proto   (err_proto)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Inputs held for one cycle; beat outputs expected in that cycle, registered outputs after its edge.
    typedef struct {
        logic [2:0]  start;
        logic [11:0] len;
        logic [2:0]  g;
        logic        e_bv;
        logic [1:0]  e_bo;
        logic [3:0]  e_bi;
        logic [2:0]  e_r;
        logic [2:0]  e_busy;
        logic [2:0]  e_done;
        logic [2:0]  e_tmo;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic [2:0] st, logic [11:0] ln, logic [2:0] gg,
                                logic bv, logic [1:0] bo, logic [3:0] bi,
                                logic [2:0] er, logic [2:0] eb, logic [2:0] ed, logic [2:0] et);
        vec_t v;
        v.start = st; v.len = ln; v.g = gg;
        v.e_bv = bv; v.e_bo = bo; v.e_bi = bi;
        v.e_r = er; v.e_busy = eb; v.e_done = ed; v.e_tmo = et;
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input int k);
        @(negedge clk);
        start = v.start; len = v.len; g = v.g;
        #1;
        check($sformatf("v%0d.beat_valid", k), beat_valid, v.e_bv);
        check($sformatf("v%0d.beat_owner", k), beat_owner, v.e_bo);
        check($sformatf("v%0d.beat_idx", k), beat_idx, v.e_bi);
        @(posedge clk); #1;
        check($sformatf("v%0d.r", k), r, v.e_r);
        check($sformatf("v%0d.busy", k), busy, v.e_busy);
        check($sformatf("v%0d.done", k), done, v.e_done);
        check($sformatf("v%0d.err_timeout", k), err_timeout, v.e_tmo);
        check($sformatf("v%0d.err_proto", k), err_proto, 1'b0);
    endtask

    task automatic check_all_reset(input string tag);
        check({tag, ".r"}, r, 3'b000);
        check({tag, ".busy"}, busy, 3'b000);
        check({tag, ".done"}, done, 3'b000);
        check({tag, ".err_timeout"}, err_timeout, 3'b000);
        check({tag, ".beat_valid"}, beat_valid, 1'b0);
        check({tag, ".beat_owner"}, beat_owner, 2'd0);
        check({tag, ".beat_idx"}, beat_idx, 4'd0);
        check({tag, ".err_proto"}, err_proto, 1'b0);
    endtask

    initial begin
        rst = 1'b1; start = '0; len = '0; g = '0;
        repeat (2) @(posedge clk);
        #1;
        check_all_reset("reset");
        @(negedge clk);
        rst = 1'b0;

        // Single burst, client 1, len=2; then a restart in the done cycle with len=0.
        //             start   len      g       bv  bo  bi   r       busy    done    tmo
        vecs.push_back(mk(3'b010, 12'h020, 3'b000, 0, 0, 0, 3'b010, 3'b010, 3'b000, 3'b000));
        vecs.push_back(mk(3'b000, 12'h020, 3'b010, 0, 0, 0, 3'b010, 3'b010, 3'b000, 3'b000));
        vecs.push_back(mk(3'b000, 12'h020, 3'b010, 1, 1, 0, 3'b010, 3'b010, 3'b000, 3'b000));
        vecs.push_back(mk(3'b000, 12'h020, 3'b010, 1, 1, 1, 3'b010, 3'b010, 3'b000, 3'b000));
        vecs.push_back(mk(3'b000, 12'h020, 3'b010, 1, 1, 2, 3'b000, 3'b000, 3'b010, 3'b000));
        vecs.push_back(mk(3'b010, 12'h000, 3'b000, 0, 0, 0, 3'b010, 3'b010, 3'b000, 3'b000));
        vecs.push_back(mk(3'b000, 12'h000, 3'b010, 0, 0, 0, 3'b010, 3'b010, 3'b000, 3'b000));
        vecs.push_back(mk(3'b000, 12'h000, 3'b010, 1, 1, 0, 3'b000, 3'b000, 3'b010, 3'b000));
        vecs.push_back(mk(3'b000, 12'h000, 3'b000, 0, 0, 0, 3'b000, 3'b000, 3'b000, 3'b000));
        // Contention: all three start with len=0, round-robin grants; start[1] while in REQ is ignored.
        vecs.push_back(mk(3'b111, 12'h000, 3'b000, 0, 0, 0, 3'b111, 3'b111, 3'b000, 3'b000));
        vecs.push_back(mk(3'b000, 12'h000, 3'b001, 0, 0, 0, 3'b111, 3'b111, 3'b000, 3'b000));
        vecs.push_back(mk(3'b000, 12'h000, 3'b001, 1, 0, 0, 3'b110, 3'b110, 3'b001, 3'b000));
        vecs.push_back(mk(3'b010, 12'h000, 3'b010, 0, 0, 0, 3'b110, 3'b110, 3'b000, 3'b000));
        vecs.push_back(mk(3'b000, 12'h000, 3'b010, 1, 1, 0, 3'b100, 3'b100, 3'b010, 3'b000));
        vecs.push_back(mk(3'b000, 12'h000, 3'b100, 0, 0, 0, 3'b100, 3'b100, 3'b000, 3'b000));
        vecs.push_back(mk(3'b000, 12'h000, 3'b100, 1, 2, 0, 3'b000, 3'b000, 3'b100, 3'b000));
        vecs.push_back(mk(3'b000, 12'h000, 3'b000, 0, 0, 0, 3'b000, 3'b000, 3'b000, 3'b000));
        // Stall: client 0, len=3, grant dropped for two cycles after beat 1.
        vecs.push_back(mk(3'b001, 12'h003, 3'b000, 0, 0, 0, 3'b001, 3'b001, 3'b000, 3'b000));
        vecs.push_back(mk(3'b000, 12'h003, 3'b001, 0, 0, 0, 3'b001, 3'b001, 3'b000, 3'b000));
        vecs.push_back(mk(3'b000, 12'h003, 3'b001, 1, 0, 0, 3'b001, 3'b001, 3'b000, 3'b000));
        vecs.push_back(mk(3'b000, 12'h003, 3'b001, 1, 0, 1, 3'b001, 3'b001, 3'b000, 3'b000));
        vecs.push_back(mk(3'b000, 12'h003, 3'b000, 0, 0, 0, 3'b001, 3'b001, 3'b000, 3'b000));
        vecs.push_back(mk(3'b000, 12'h003, 3'b000, 0, 0, 0, 3'b001, 3'b001, 3'b000, 3'b000));
        vecs.push_back(mk(3'b000, 12'h003, 3'b001, 1, 0, 2, 3'b001, 3'b001, 3'b000, 3'b000));
        vecs.push_back(mk(3'b000, 12'h003, 3'b001, 1, 0, 3, 3'b000, 3'b000, 3'b001, 3'b000));
        vecs.push_back(mk(3'b000, 12'h000, 3'b000, 0, 0, 0, 3'b000, 3'b000, 3'b000, 3'b000));

        foreach (vecs[k]) run_vec(vecs[k], k);

        // Timeout: client 2 never granted -> abort on the 15th wait edge.
        @(negedge clk);
        start = 3'b100; len = 12'h000; g = 3'b000;
        @(posedge clk); #1;
        check("tmo.r_rise", r, 3'b100);
        @(negedge clk);
        start = 3'b000;
        for (int e = 1; e <= 15; e++) begin
            @(posedge clk); #1;
            if (e < 15) begin
                check($sformatf("tmo.wait%0d.err", e), err_timeout, 3'b000);
                check($sformatf("tmo.wait%0d.r", e), r, 3'b100);
            end else begin
                check("tmo.fire.err", err_timeout, 3'b100);
                check("tmo.fire.r", r, 3'b000);
                check("tmo.fire.busy", busy, 3'b000);
            end
        end
        @(posedge clk); #1;
        check("tmo.pulse_end", err_timeout, 3'b000);

        // Grant arriving exactly on wait edge 15 wins over the timeout.
        @(negedge clk);
        start = 3'b100;
        @(posedge clk);
        @(negedge clk);
        start = 3'b000;
        repeat (14) @(posedge clk);
        @(negedge clk);
        g = 3'b100;
        @(posedge clk); #1;
        check("tmo_race.err", err_timeout, 3'b000);
        check("tmo_race.r", r, 3'b100);
        check("tmo_race.busy", busy, 3'b100);
        @(negedge clk); #1;
        check("tmo_race.beat_valid", beat_valid, 1'b1);
        check("tmo_race.beat_owner", beat_owner, 2'd2);
        @(posedge clk); #1;
        check("tmo_race.done", done, 3'b100);
        check("tmo_race.err2", err_timeout, 3'b000);
        @(negedge clk);
        g = 3'b000;
        @(posedge clk); #1;
        check("tmo_race.done_end", done, 3'b000);

        // Reset during beat 1 of a 4-beat burst.
        @(negedge clk);
        start = 3'b001; len = 12'h003; g = 3'b000;
        @(posedge clk);
        @(negedge clk);
        start = 3'b000; g = 3'b001;
        @(posedge clk);
        @(negedge clk); #1;
        check("rst_mid.beat0", beat_idx, 4'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_mid.beat1_valid", beat_valid, 1'b1);
        check("rst_mid.beat1_idx", beat_idx, 4'd1);
        @(posedge clk); #1;
        check_all_reset("rst_mid");
        @(negedge clk);
        rst = 1'b0; g = 3'b000;
        @(posedge clk); #1;
        check("rst_mid.no_done", done, 3'b000);
        check("rst_mid.r_low", r, 3'b000);

        // Protocol checker: non-one-hot grant to idle clients.
        @(negedge clk);
        g = 3'b011;
        @(posedge clk); #1;
        check("proto.set", err_proto, EXP_PROTO);
        @(negedge clk);
        g = 3'b000;
        repeat (3) @(posedge clk);
        #1;
        check("proto.sticky", err_proto, EXP_PROTO);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("proto.cleared", err_proto, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/arb_requester.md
# arb_requester

Client-side front end for the three-way round-robin arbiter: converts per-client transfer commands into held request lines, consumes the one-hot grant vector, and sequences a multi-beat ownership burst per client before releasing the request. It sits between the client engines and the arbiter's `r`/`g` ports. It is the initiator end of the request/grant protocol the arbiter serves.

## Interface
- `N`, 3: number of clients; must match the arbiter width.
- `LEN_W`, 4: burst-length field width; `len` encodes beats−1.
- `TIMEOUT`, 15: maximum cycles a client waits in REQ before aborting; range 1..255.

- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  N  per-client command strobe; sampled only in IDLE.
- `len`  in  N*LEN_W  per-client burst length minus one; client i uses bits `[i*LEN_W +: LEN_W]`; sampled with `start`.
- `r`  out  N  request vector to arbiter.
- `g`  in  N  grant vector from arbiter.
- `busy`  out  N  client i not in IDLE.
- `done`  out  N  one-cycle pulse: burst completed.
- `err_timeout`  out  N  one-cycle pulse: request aborted after `TIMEOUT`.
- `beat_valid`  out  1  a granted beat occurs this cycle.
- `beat_owner`  out  $clog2(N)  index of the client owning the beat; 0 when `beat_valid`=0.
- `beat_idx`  out  LEN_W  beat number within the burst (0-based).
- `err_proto`  out  1  sticky protocol-violation flag (see Configuration).

## Operation
- One independent FSM per client: IDLE → REQ → OWN → IDLE.
- IDLE: `r[i]`=0. `start[i]`=1 latches `len[i]`, clears the wait and beat counters, and moves to REQ.
- REQ: `r[i]`=1. On the edge with `g[i]`=1, move to OWN. If `g[i]`=0 for `TIMEOUT` consecutive edges, return to IDLE and pulse `err_timeout[i]`. If the grant and timeout coincide on the same edge, the grant wins.
- OWN: `r[i]`=1.
  - Each cycle with `g[i]`=1 is one beat: `beat_valid`=1, `beat_owner`=i, `beat_idx` = beat counter; the counter increments on the edge.
  - A cycle with `g[i]`=0 in OWN is a stall: no beat, and the counter holds.
  - The edge that completes beat `len[i]` moves to IDLE and pulses `done[i]`.
- The number of beats per burst is exactly `len`+1. With `len`=0 the burst is a single beat.
- `start[i]` outside IDLE is ignored and not queued.
- `beat_valid`, `beat_owner` and `beat_idx` are combinational from state, `g` and the counters. All other outputs are registered.
- With multiple clients in OWN, only a granted client beats. Under a legal one-hot grant at most one beats per cycle; if several beat, `beat_owner` reports the lowest index.

## Timing
- Reset values: `r`=0, `busy`=0, `done`=0, `err_timeout`=0, `beat_valid`=0, `beat_owner`=0, `beat_idx`=0, `err_proto`=0. All FSMs go to IDLE and all counters clear.
- Reset mid-burst: the next edge drops `r` and returns to IDLE. No `done` or `err_timeout` pulse is issued.
- Start to request: `start` at edge k gives `r[i]`=1 from edge k+1.
- Grant to first beat: the first beat occurs in the first cycle after the REQ→OWN edge in which `g[i]`=1. The grant cycle seen in REQ is not itself a beat.
- Release: the final-beat edge drops `r[i]` and raises `done[i]` in the same following cycle. `start[i]` in that `done` cycle is accepted.
- `TIMEOUT` wait counter width: 8 bits, saturating. `beat_idx` wraps only past `len`, which never happens.

## Configuration
- `ARB_REQ_CHECK_EN` defined: a protocol checker is compiled in. It sets `err_proto` (sticky until `rst`) on any cycle where:
  - `g` is not zero or one-hot, or
  - `g[i]`=1 while `r[i]`=0.
- Not defined: the checker logic is absent and `err_proto` is tied to 0.

## Test plan
- Single burst: `start[1]`=1 with `len[1]`=2; grant `g`=3'b010 continuously from the cycle after `r[1]` rises → 3 beats with `beat_owner`=1 and `beat_idx` 0,1,2, then `done[1]` pulses once and `r[1]` falls the same cycle.
- Contention: `start`=3'b111 with all `len`=0 and a round-robin grant model → each client gets exactly one beat, three `done` pulses total, and `beat_valid` is never asserted for two owners at once.
- Stall: client 0, `len`=3; drop `g[0]` for 2 cycles after beat 1 → `beat_idx` sequence 0,1,(stall),(stall),2,3, then `done[0]`.
- Timeout: `start[2]` with `g` held at 0 → `err_timeout[2]` pulses after 15 wait edges, `r[2]`=0 and `busy[2]`=0 the same cycle. A second run with the grant arriving exactly on edge 15 → OWN is entered and no error pulse is issued.
- Reset mid-burst: assert `rst` during beat 1 of a 4-beat burst → the next cycle has all outputs at their reset values and no `done` pulse.
- Checker (with `ARB_REQ_CHECK_EN`): drive `g`=3'b011 for one cycle → `err_proto`=1 and it stays high until `rst`. Without the macro, the same stimulus gives `err_proto`=0.
